// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch history table.
// Counter encoding, FSM states and the update-stage bundle.
package branch_predictor_pkg;

   localparam int XLEN = 32;
   localparam int BP_IDX_MAX_W = 16;

   localparam logic [1:0] BP_SNT = 2'b00;
   localparam logic [1:0] BP_WNT = 2'b01;
   localparam logic [1:0] BP_WT  = 2'b10;
   localparam logic [1:0] BP_ST  = 2'b11;

   typedef enum logic {
      BP_INIT,
      BP_READY
   } bp_state_t;

   typedef struct packed {
      logic                    vld;
      logic [BP_IDX_MAX_W-1:0] idx;
      logic                    taken;
   } bp_upd_t;

   // Shared by lookup and update so both index the table identically
   function automatic logic [BP_IDX_MAX_W-1:0] bp_pc_idx(
      input logic [XLEN-1:0] pc,
      input int              iw
   );
      logic [XLEN-1:0] mask;
      mask = (XLEN'(1) << iw) - XLEN'(1);
      return BP_IDX_MAX_W'((pc >> 2) & mask);
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute resolve and prediction signals.
// The core side is master, the predictor is slave.
interface branch_predictor_if;
   import branch_predictor_pkg::*;

   logic            ifu_fetch_vld;
   logic [XLEN-1:0] ifu_fetch_pc;
   logic            exu_is_branch;
   logic            exu_branch_taken;
   logic [XLEN-1:0] exu_branch_pc;
   logic            bp_predict_vld;
   logic            bp_predict_taken;
   logic            bp_ready;

   modport master (
      output ifu_fetch_vld,
      output ifu_fetch_pc,
      output exu_is_branch,
      output exu_branch_taken,
      output exu_branch_pc,
      input  bp_predict_vld,
      input  bp_predict_taken,
      input  bp_ready
   );

   modport slave (
      input  ifu_fetch_vld,
      input  ifu_fetch_pc,
      input  exu_is_branch,
      input  exu_branch_taken,
      input  exu_branch_pc,
      output bp_predict_vld,
      output bp_predict_taken,
      output bp_ready
   );

endinterface

// File: rtl/branch_predictor_sat_cnt2.sv
// Two-bit saturating counter next-value function.
// Taken counts up to ST, not-taken counts down to SNT.
module bp_sat_cnt2
   import branch_predictor_pkg::*;
(
   input  logic [1:0] cnt,
   input  logic       taken,
   output logic [1:0] cnt_next
);

   always_comb begin
      cnt_next = cnt;
      unique case (1'b1)
         taken && (cnt != BP_ST):   cnt_next = cnt + 2'd1;
         !taken && (cnt != BP_SNT): cnt_next = cnt - 2'd1;
         default: ;
      endcase
   end

endmodule

// File: rtl/dff_rst.sv
// Generic register with synchronous active-low reset.
// Reset value is set per instance.
module dff_rst #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst_n) q <= RST_VAL;
      else        q <= d;
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT of 2-bit counters with an init sweep,
// a two-stage update pipe and write-first lookup forwarding.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int         BHT_DEPTH  = 256,
   parameter logic [1:0] INIT_VALUE = BP_WNT
) (
   input  logic               clk,
   input  logic               rst_n,
   branch_predictor_if.slave  bp
);

   localparam int IW = $clog2(BHT_DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(BHT_DEPTH - 1);

   logic [1:0] tbl [BHT_DEPTH];

   bp_state_t state;
   logic [IW-1:0] sweep_idx;
   logic is_ready;

   bp_upd_t upd_d;
   bp_upd_t upd_q;
   logic [1:0] upd_cur;
   logic [1:0] upd_next;

   logic [BP_IDX_MAX_W-1:0] lk_idx;
   logic [1:0] lk_cnt;

   logic vld_d;
   logic taken_d;
   logic ready_d;
   logic vld_q;
   logic taken_q;
   logic ready_q;

   assign is_ready = (state == BP_READY);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= BP_INIT;
         sweep_idx <= '0;
      end else begin
         unique case (state)
            BP_INIT: begin
               if (sweep_idx == LAST_IDX) state <= BP_READY;
               else sweep_idx <= sweep_idx + 1'b1;
            end
            BP_READY: ;
            default: state <= BP_INIT;
         endcase
      end
   end

   // Sweep owns the write port until ready; updates only exist after
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == BP_INIT)
            tbl[sweep_idx] <= INIT_VALUE;
         else if (upd_q.vld)
            tbl[upd_q.idx[IW-1:0]] <= upd_next;
      end
   end

   always_comb begin
      upd_d       = '0;
      upd_d.vld   = bp.exu_is_branch & is_ready;
      upd_d.idx   = bp_pc_idx(bp.exu_branch_pc, IW);
      upd_d.taken = bp.exu_branch_taken;
   end

   dff_rst #(
      .W       ($bits(bp_upd_t)),
      .RST_VAL ('0)
   ) u_upd (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (upd_d),
      .q     (upd_q)
   );

   assign upd_cur = tbl[upd_q.idx[IW-1:0]];

   bp_sat_cnt2 u_sat (
      .cnt      (upd_cur),
      .taken    (upd_q.taken),
      .cnt_next (upd_next)
   );

   always_comb begin
      lk_idx = bp_pc_idx(bp.ifu_fetch_pc, IW);
      lk_cnt = tbl[lk_idx[IW-1:0]];
      if (upd_q.vld && (upd_q.idx == lk_idx)) lk_cnt = upd_next;
   end

   assign vld_d   = bp.ifu_fetch_vld;
   assign taken_d = bp.ifu_fetch_vld & is_ready & lk_cnt[1];
   assign ready_d = is_ready | (sweep_idx == LAST_IDX);

   dff_rst #(.W(1)) u_vld (
      .clk (clk), .rst_n (rst_n), .d (vld_d), .q (vld_q)
   );

   dff_rst #(.W(1)) u_taken (
      .clk (clk), .rst_n (rst_n), .d (taken_d), .q (taken_q)
   );

   dff_rst #(.W(1)) u_ready (
      .clk (clk), .rst_n (rst_n), .d (ready_d), .q (ready_q)
   );

   assign bp.bp_predict_vld   = vld_q;
   assign bp.bp_predict_taken = taken_q;
   assign bp.bp_ready         = ready_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor with a queue of expected
// {vld, taken, ready} triples checked one cycle after each drive.
module tb_branch_predictor;

   logic clk;
   logic rst_n;

   branch_predictor_if bif ();

   branch_predictor dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bp    (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_bad;
   logic [2:0] exp_q [$];

   task automatic step(
      input logic        fv,
      input logic [31:0] fpc,
      input logic        br,
      input logic        tk,
      input logic [31:0] bpc,
      input logic        ev,
      input logic        et,
      input logic        er,
      input string       tag
   );
      logic [2:0] e;
      logic [2:0] got;
      bif.ifu_fetch_vld    = fv;
      bif.ifu_fetch_pc     = fpc;
      bif.exu_is_branch    = br;
      bif.exu_branch_taken = tk;
      bif.exu_branch_pc    = bpc;
      exp_q.push_back({ev, et, er});
      @(posedge clk);
      #1;
      e   = exp_q.pop_front();
      got = {bif.bp_predict_vld, bif.bp_predict_taken, bif.bp_ready};
      n_vec++;
      assert (got === e) else begin
         n_bad++;
         $error("FAIL %s: vld/taken/ready got %b expected %b", tag, got, e);
      end
   endtask

   task automatic upd(input logic tk, input logic [31:0] pc, input string tag);
      step(1'b0, 32'h0, 1'b1, tk, pc, 1'b0, 1'b0, 1'b1, tag);
   endtask

   task automatic look(input logic [31:0] pc, input logic et, input string tag);
      step(1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b1, et, 1'b1, tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;

      for (int i = 0; i < 3; i++)
         step(1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, "reset");

      // Branches during the sweep must be dropped
      rst_n = 1'b1;
      for (int i = 1; i <= 256; i++)
         step(1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 1'b1, 1'b0, (i == 256), "init");

      look(32'h100, 1'b0, "init_wnt");
      look(32'h80, 1'b0, "init_upd_drop");

      upd(1'b1, 32'h80, "sat_u1");
      upd(1'b1, 32'h80, "sat_u2");
      upd(1'b1, 32'h80, "sat_u3");
      look(32'h80, 1'b1, "sat_st");
      upd(1'b0, 32'h80, "sat_u4");
      look(32'h80, 1'b1, "sat_wt");
      upd(1'b0, 32'h80, "sat_u5");
      look(32'h80, 1'b0, "sat_wnt");
      upd(1'b0, 32'h80, "sat_u6");
      upd(1'b0, 32'h80, "sat_u7");
      upd(1'b1, 32'h80, "sat_u8");
      look(32'h80, 1'b0, "sat_bot");
      upd(1'b1, 32'h80, "sat_u9");
      look(32'h80, 1'b1, "sat_bot2");
      upd(1'b0, 32'h80, "sat_u10");

      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1, "gate_br1");
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b1, "gate_br2");
      look(32'h80, 1'b0, "gate_br");
      step(1'b0, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "gate_fv");

      upd(1'b1, 32'h000, "alias_u1");
      upd(1'b1, 32'h000, "alias_u2");
      look(32'h400, 1'b1, "alias");
      look(32'h004, 1'b0, "alias_nb");
      upd(1'b0, 32'h400, "alias_u3");
      look(32'h000, 1'b1, "alias_st");

      step(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b1, "fwd_old");
      step(1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 1'b1, "fwd_new");
      step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, "fwd_b2b");
      upd(1'b0, 32'h40, "b2b_u");
      look(32'h40, 1'b1, "b2b_no_loss");

      upd(1'b1, 32'h80, "pre_u1");
      upd(1'b1, 32'h80, "pre_u2");
      look(32'h80, 1'b1, "pre_rst");
      upd(1'b1, 32'h80, "pre_u3");
      rst_n = 1'b0;
      step(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "rst_mid");
      rst_n = 1'b1;
      for (int i = 1; i <= 256; i++)
         step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, (i == 256), "reinit");
      look(32'h80, 1'b0, "rst_hist");
      look(32'h40, 1'b0, "rst_hist2");
      look(32'h000, 1'b0, "rst_hist3");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
